// File: rtl/ctr_64.sv
// ctr_64 : modulo-64 up/down counter split into a 4-bit low field (rg_a)
// and a 2-bit high field (bit_a). The full count is {bit_a, rg_a}.
// Priority on each edge: clr, then ld, then count (en) up or down, else hold.
// tc is combinational from the registered count and the current direction.
// Optional build macro: CTR64_SATURATE_EN makes counting stop at 63 (up)
// or 0 (down) instead of wrapping. ld and clr are not affected by it.
module ctr_64 #(
  parameter int LO_W = 4,
  parameter int HI_W = 2
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [LO_W+HI_W-1:0] ld_val,
  output logic [LO_W-1:0]      rg_a,
  output logic [HI_W-1:0]      bit_a,
  output logic                 tc
);

  localparam int CNT_W   = LO_W + HI_W;
  localparam int MAX_CNT = 2**CNT_W - 1;

`ifdef CTR64_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [LO_W-1:0] lo_q, lo_d;
  logic [HI_W-1:0] hi_q, hi_d;

  // True when the count sits at the end of travel for the given direction:
  // 63 when counting up, 0 when counting down.
  function automatic logic at_limit(input logic [LO_W-1:0] lo,
                                    input logic [HI_W-1:0] hi,
                                    input logic            dir_up);
    if (dir_up) return ({hi, lo} == CNT_W'(MAX_CNT));
    else        return ({hi, lo} == '0);
  endfunction

  // Low field always steps by one; it wraps 15->0 up and 0->15 down.
  function automatic logic [LO_W-1:0] step_lo(input logic [LO_W-1:0] lo,
                                              input logic            dir_up);
    if (dir_up) return lo + LO_W'(1);
    else        return lo - LO_W'(1);
  endfunction

  // High field moves only on the low-field carry (15->0) or borrow (0->15),
  // in the same edge as the low-field wrap.
  function automatic logic [HI_W-1:0] step_hi(input logic [HI_W-1:0] hi,
                                              input logic [LO_W-1:0] lo,
                                              input logic            dir_up);
    if (dir_up) return hi + HI_W'(&lo);
    else        return hi - HI_W'(~|lo);
  endfunction

  // Next-state selection in priority order; saturation only blocks counting.
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (clr) begin
      lo_d = '0;
      hi_d = '0;
    end else if (ld) begin
      lo_d = ld_val[LO_W-1:0];
      hi_d = ld_val[CNT_W-1:LO_W];
    end else if (en && !(SAT && at_limit(lo_q, hi_q, up))) begin
      lo_d = step_lo(lo_q, up);
      hi_d = step_hi(hi_q, lo_q, up);
    end
  end

  // Count register; reset clears it immediately, independent of the clock.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign rg_a  = lo_q;
  assign bit_a = hi_q;
  assign tc    = at_limit(lo_q, hi_q, up);

endmodule

// File: tb/tb_ctr_64.sv
// tb_ctr_64 : directed bench for ctr_64. Expected values are hand-derived;
// the saturating build (CTR64_SATURATE_EN) selects its own expectations.
module tb_ctr_64;

  logic       clock = 1'b0;
  logic       rst, en, up, clr, ld;
  logic [5:0] ld_val;
  logic [3:0] rg_a;
  logic [1:0] bit_a;
  logic       tc;
  logic [5:0] cnt;

  int total = 0;
  int bad   = 0;

`ifdef CTR64_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  ctr_64 dut (
    .clock (clock),
    .rst   (rst),
    .en    (en),
    .up    (up),
    .clr   (clr),
    .ld    (ld),
    .ld_val(ld_val),
    .rg_a  (rg_a),
    .bit_a (bit_a),
    .tc    (tc)
  );

  always #5 clock = ~clock;

  assign cnt = {bit_a, rg_a};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_c;
    rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; ld = 1'b0; ld_val = '0;

    // Reset state before any clock edge
    #2;
    chk("rst_cnt", 8'(cnt), 8'h00);
    chk("rst_tc_up", 8'(tc), 8'h0);
    up = 1'b0;
    #1;
    chk("rst_tc_dn", 8'(tc), 8'h1);
    up = 1'b1;
    en = 1'b1;
    edge1();
    chk("rst_hold", 8'(cnt), 8'h00);

    // 70 up-count edges from 0
    rst = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      edge1();
      exp_c = SAT ? ((k > 63) ? 63 : k) : (k % 64);
      chk("up70_cnt", 8'(cnt), 8'(exp_c));
      chk("up70_tc", 8'(tc), 8'(exp_c == 63));
    end
    if (!SAT) chk("up70_final", 8'(cnt), 8'h06);

    // Async reset mid-count at 37
    en = 1'b0; ld = 1'b1; ld_val = 6'd37;
    edge1();
    ld = 1'b0;
    chk("ld37", 8'(cnt), 8'd37);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", 8'(cnt), 8'h00);
    en = 1'b1; ld = 1'b1; ld_val = 6'd9;
    for (int k = 0; k < 6; k++) begin
      edge1();
      chk("rst_ignore", 8'(cnt), 8'h00);
    end
    ld = 1'b0;
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge1();
      chk("restart", 8'(cnt), 8'(k));
    end

    // Down-count through zero
    en = 1'b0; ld = 1'b1; ld_val = 6'h01;
    edge1();
    ld = 1'b0;
    chk("dn_ld1", 8'(cnt), 8'h01);
    en = 1'b1; up = 1'b0;
    edge1();
    chk("dn_0", 8'(cnt), 8'h00);
    chk("dn_0_tc", 8'(tc), 8'h1);
    edge1();
    chk("dn_wrap", 8'(cnt), SAT ? 8'h00 : 8'd63);
    chk("dn_wrap_tc", 8'(tc), SAT ? 8'h1 : 8'h0);
    edge1();
    chk("dn_next", 8'(cnt), SAT ? 8'h00 : 8'd62);

    // Down-count borrow 0x10 -> 0x0F
    en = 1'b0; ld = 1'b1; ld_val = 6'h10;
    edge1();
    ld = 1'b0; en = 1'b1;
    edge1();
    chk("borrow_lo", 8'(rg_a), 8'hF);
    chk("borrow_hi", 8'(bit_a), 8'h0);

    // clr beats ld beats count
    up = 1'b1; en = 1'b1; clr = 1'b1; ld = 1'b1; ld_val = 6'h2A;
    edge1();
    chk("prio_clr", 8'(cnt), 8'h00);
    clr = 1'b0; en = 1'b0;
    edge1();
    ld = 1'b0;
    chk("ld_lo", 8'(rg_a), 8'hA);
    chk("ld_hi", 8'(bit_a), 8'h2);

    // clr without en
    clr = 1'b1;
    edge1();
    clr = 1'b0;
    chk("clr_noen", 8'(cnt), 8'h00);

    // Enable hold at 15, then carry into high field
    ld = 1'b1; ld_val = 6'd15;
    edge1();
    ld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk("en_hold", 8'(cnt), 8'd15);
    end
    en = 1'b1;
    edge1();
    chk("carry_lo", 8'(rg_a), 8'h0);
    chk("carry_hi", 8'(bit_a), 8'h1);

    // Top of range: saturate or wrap
    en = 1'b0; ld = 1'b1; ld_val = 6'd62;
    edge1();
    ld = 1'b0; en = 1'b1;
    chk("top_62_tc", 8'(tc), 8'h0);
    edge1();
    chk("top_63", 8'(cnt), 8'd63);
    chk("top_63_tc", 8'(tc), 8'h1);
    edge1();
    chk("top_next", 8'(cnt), SAT ? 8'd63 : 8'd0);
    chk("top_next_tc", 8'(tc), SAT ? 8'h1 : 8'h0);
    edge1();
    chk("top_next2", 8'(cnt), SAT ? 8'd63 : 8'd1);
    chk("top_next2_tc", 8'(tc), SAT ? 8'h1 : 8'h0);

    // tc follows up directly, not en
    en = 1'b0; clr = 1'b1;
    edge1();
    clr = 1'b0;
    chk("tc_up_at0", 8'(tc), 8'h0);
    up = 1'b0;
    #1;
    chk("tc_dn_at0", 8'(tc), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctr_64.md
Name: ctr_64

Overview:
- Modulo-64 binary counter, split into a 4-bit low field (rg_a) and a 2-bit high field (bit_a).
- Full count = {bit_a, rg_a}, range 0..63.
- Used as a general-purpose event/tick counter and as a nibble/page index source for display and sequencing logic.
- Single clock domain; count advances on the rising clock edge.

Parameters:
- LO_W, 4, width of low field rg_a
- HI_W, 2, width of high field bit_a
- MAX_CNT, 2**(LO_W+HI_W)-1 = 63, terminal count value; derived, not overridden

Ports:
- clock  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable; 1 = count this cycle
- up  input  1  direction; 1 = increment, 0 = decrement
- clr  input  1  synchronous clear to 0
- ld  input  1  synchronous load of ld_val
- ld_val  input  6  load value, {hi[1:0], lo[3:0]}
- rg_a  output  4  low field of count (count[3:0])
- bit_a  output  2  high field of count (count[5:4])
- tc  output  1  terminal-count flag, combinational

Behaviour:
- Reset, asynchronous on rst = 0:
  - rg_a = 0, bit_a = 0 immediately, without waiting for a clock edge.
  - Holds while rst = 0; all other inputs ignored.
- Counting resumes on the first rising edge after rst returns to 1.
- Per-edge priority, when rst = 1:
  - clr: count <= 0
  - else ld: count <= ld_val
  - else en && up: count <= count + 1
  - else en && !up: count <= count - 1
  - else: hold
- clr and ld are synchronous and do not require en.
- Carry and borrow:
  - rg_a increments 0..15.
  - On the 15 -> 0 transition while counting up, bit_a increments in the same edge.
  - While counting down, bit_a decrements when rg_a goes 0 -> 15.
- Wrap-around, default build: 63 + 1 -> 0 and 0 - 1 -> 63. No stall, no extra cycle.
- tc:
  - up = 1: tc = 1 when count == 63.
  - up = 0: tc = 1 when count == 0.
  - tc is not gated by en.
  - tc is 0 during reset when up = 1, and 1 during reset when up = 0.
- Latency:
  - Outputs reflect the new value one clock after a qualifying edge.
  - Outputs are registered; tc is combinational from the registered count and up.
- Reset asserted mid-count: the count is lost; restart from 0.
- Simultaneous clr and ld: clr wins.

Optional Feature:
- Macro CTR64_SATURATE_EN.
- Defined:
  - Counting up holds at 63 when en = 1 and count = 63.
  - Counting down holds at 0.
  - ld and clr are unaffected.
- Undefined: modulo-64 wrap as specified above.

Test Plan:
- Reset and count: pulse rst low, then rst = 1, en = 1, up = 1 for 70 edges -> rg_a cycles 0..F four times with bit_a stepping 0,1,2,3,0. Check tc = 1 only while count == 63, and the count is 6 after edge 70.
- Async reset mid-count: drop rst low between edges when count = 37 -> outputs read 0 before the next edge and hold 0 for 6 edges. Release rst -> 1,2,3,4 on the next 4 edges.
- Down-count wrap: ld_val = 6'h01, ld = 1 for one edge, then en = 1, up = 0 -> count 1, 0 (tc = 1), 63, 62. With CTR64_SATURATE_EN defined -> 1, 0, 0, 0.
- Priority: clr = 1, ld = 1, ld_val = 6'h2A, en = 1 in the same edge -> count 0. Then ld only -> rg_a = A, bit_a = 2.
- Enable hold: count = 15, en = 0 for 3 edges -> stays 15. en = 1 -> rg_a = 0, bit_a = 1.
- Saturation build: count 62, en = 1, up = 1 -> 63, 63, 63 with tc = 1 throughout. Default build -> 63, 0, 1.
